// File: rtl/fpga_cfg_pkg.sv
// Shared fixed-point format and counter widths for the inverse-CDF datapath.
// The largest positive code is derived here so every block clamps to the same limit.
package fpga_cfg_pkg;

    localparam int FP_WIDTH = 32;
    localparam int FP_QINT  = 15;
    localparam int FP_QFRAC = 16;

    localparam int SAMPLE_CNT_W = 32;
    localparam int SAT_CNT_W    = 16;

    // Largest positive two's-complement value for a word of width w, i.e. 2^(w-1)-1.
    function automatic logic [63:0] maxpos(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One valid/ready register slice. It accepts new data while empty or while its
// contents are leaving in the same cycle, so a chain of slices sustains one beat per cycle.
module pipe_stage_reg #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         load;

    assign ready_o = !valid_q || ready_i;
    assign load    = valid_i && ready_o;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/inverse_cdf_sign_restore.sv
// Restores the sign of a z-score computed on the folded half of the CDF.
// S1 clamps the magnitude to the symmetric range; S2 applies the sign. Both stages stall via ready.
module inverse_cdf_sign_restore
    import fpga_cfg_pkg::*;
#(
    parameter int WIDTH = FP_WIDTH,
    parameter int QINT  = FP_QINT,
    parameter int QFRAC = FP_QFRAC
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    output logic                    ready_out,
    input  logic [WIDTH-1:0]        z_mag,
    input  logic                    negate,
    output logic                    valid_out,
    input  logic                    ready_in,
    output logic [WIDTH-1:0]        z,
    output logic                    sat,
    output logic [SAMPLE_CNT_W-1:0] sample_cnt,
    output logic [SAT_CNT_W-1:0]    sat_cnt
);

    localparam logic [WIDTH-1:0] MAXPOS = WIDTH'(maxpos(WIDTH));

    if (QINT + QFRAC + 1 != WIDTH) begin : g_fmt_err
        $error("inverse_cdf_sign_restore: QINT + QFRAC + sign bit must equal WIDTH");
    end

    logic [WIDTH-1:0] clamp_mag;
    logic             clamp_sat;
    logic [WIDTH+1:0] s1_data;
    logic             s1_valid, s2_ready;
    logic [WIDTH-1:0] s1_mag, signed_val;
    logic             s1_neg, s1_sat;
    logic [WIDTH:0]   s2_data;

    always_comb begin
        clamp_sat = (z_mag > MAXPOS);
        clamp_mag = clamp_sat ? MAXPOS : z_mag;
    end

    pipe_stage_reg #(.W(WIDTH + 2)) u_s1 (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (valid_in),
        .ready_o (ready_out),
        .data_i  ({clamp_sat, negate, clamp_mag}),
        .valid_o (s1_valid),
        .ready_i (s2_ready),
        .data_o  (s1_data)
    );

    assign {s1_sat, s1_neg, s1_mag} = s1_data;
    // Magnitude never exceeds MAXPOS, so negation cannot produce the most-negative code.
    assign signed_val = s1_neg ? (WIDTH'(0) - s1_mag) : s1_mag;

    pipe_stage_reg #(.W(WIDTH + 1)) u_s2 (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (s1_valid),
        .ready_o (s2_ready),
        .data_i  ({s1_sat, signed_val}),
        .valid_o (valid_out),
        .ready_i (ready_in),
        .data_o  (s2_data)
    );

    assign z   = s2_data[WIDTH-1:0];
    assign sat = s2_data[WIDTH];

    logic                    xfer;
    logic [SAMPLE_CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [SAT_CNT_W-1:0]    sat_cnt_q, sat_cnt_d;

    assign xfer = valid_out && ready_in;

    always_comb begin
        sample_cnt_d = sample_cnt_q;
        sat_cnt_d    = sat_cnt_q;
        if (xfer) begin
            sample_cnt_d = sample_cnt_q + SAMPLE_CNT_W'(1);
            if (sat && (sat_cnt_q != '1)) begin
                sat_cnt_d = sat_cnt_q + SAT_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt_q <= '0;
            sat_cnt_q    <= '0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            sat_cnt_q    <= sat_cnt_d;
        end
    end

    assign sample_cnt = sample_cnt_q;
    assign sat_cnt    = sat_cnt_q;

endmodule

// File: doc/inverse_cdf_sign_restore.md
INVERSE_CDF_SIGN_RESTORE -- requirements
Module: inverse_cdf_sign_restore

Interface
REQ-001 The module SHALL have parameter WIDTH, default fpga_cfg_pkg::FP_WIDTH, meaning total fixed-point word width.
REQ-002 The module SHALL have parameter QINT, default fpga_cfg_pkg::FP_QINT, meaning integer bits.
REQ-003 The module SHALL have parameter QFRAC, default fpga_cfg_pkg::FP_QFRAC, meaning fraction bits.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 valid_in  input  1  upstream has a folded-domain result.
REQ-007 ready_out  output  1  this block accepts input this cycle.
REQ-008 z_mag  input  WIDTH  unsigned magnitude of the z-score, computed on the folded half x in (0,0.5].
REQ-009 negate  input  1  fold flag; 1 means the final z-score is negative.
REQ-010 valid_out  output  1  z holds a result.
REQ-011 ready_in  input  1  downstream accepts z.
REQ-012 z  output  WIDTH  signed Q(QINT).(QFRAC) z-score.
REQ-013 sat  output  1  the result on z was clamped.
REQ-014 sample_cnt  output  32  count of results accepted by downstream.
REQ-015 sat_cnt  output  16  count of clamped results accepted by downstream.

Function
REQ-016 Pipeline SHALL be two registered stages: S1 (clamp), then S2 (sign apply). Latency SHALL be 2 cycles, input accept to valid_out, when not stalled.
REQ-017 Input SHALL be accepted iff valid_in && ready_out.
REQ-018 A stage SHALL advance when its successor is empty or advancing.
REQ-019 ready_out SHALL be !s1_valid || s1_advance, combinational; sustained throughput SHALL be 1 sample per cycle with ready_in=1.
REQ-020 S1: MAXPOS = 2^(WIDTH-1)-1.
REQ-021 S1: if z_mag > MAXPOS, then mag=MAXPOS and sat=1; else mag=z_mag and sat=0.
REQ-022 S2: z = negate ? -mag : mag, in two's complement. The output range SHALL be symmetric, [-MAXPOS, +MAXPOS]. The most-negative code SHALL never be emitted.
REQ-023 z_mag=0 with negate=1 SHALL give z=0.
REQ-024 While valid_out && !ready_in, z, sat and valid_out SHALL hold stable.
REQ-025 Upstream data held while stalled SHALL never be lost or duplicated.
REQ-026 A transfer (valid_out && ready_in) SHALL increment sample_cnt. If sat=1, it SHALL also increment sat_cnt.
REQ-027 sample_cnt SHALL wrap modulo 2^32.
REQ-028 sat_cnt SHALL saturate at 16'hFFFF.
REQ-029 Simultaneous input accept and output transfer SHALL both take effect in the same cycle.

Reset
REQ-030 On rst=1, asynchronously: S1/S2 valid=0, valid_out=0, z=0, sat=0, sample_cnt=0, sat_cnt=0.
REQ-031 ready_out SHALL be 1 once both stages are empty.
REQ-032 Reset mid-stream SHALL discard all in-flight samples. The first post-reset output SHALL be the first post-reset input.

Structure
REQ-033 MAXPOS and the counter widths (32, 16) SHALL live in fpga_cfg_pkg beside FP_WIDTH/QINT/QFRAC.
REQ-034 One sub-module, pipe_stage_reg, SHALL be instantiated twice. It holds a valid/ready register slice parameterised on payload width.

Verification (bench overrides WIDTH=32, QFRAC=16)
REQ-035 Scenario: z_mag=0x0001_8000 (1.5), negate=0 -> z=0x0001_8000, sat=0, 2 cycles later.
REQ-036 Scenario: same input with negate=1 -> z=0xFFFE_8000 (-1.5), sat=0.
REQ-037 Scenario: z_mag=0x8000_0000, negate=1 -> z=0x8000_0001, sat=1, sat_cnt=1.
REQ-038 Scenario: stream 5 samples, ready_in low cycles 2-4 -> all 5 delivered in order, z stable during the stall, ready_out low only while both stages are full, sample_cnt=5.
REQ-039 Scenario: assert rst with 2 samples in flight -> valid_out=0 immediately, counters=0; the next input emerges first.
REQ-040 Scenario: z_mag=0, negate=1 -> z=0, sat=0.
